// File: rtl/piso4_tx.sv
// 4-bit parallel-in / serial-out transmitter with gapless back-to-back frames.
// A frame is four consecutive sout cycles qualified by frame, followed by a one-cycle done pulse.
module piso4_tx #(
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] d,
   output logic       ready,
   output logic       busy,
   output logic       sout,
   output logic       frame,
   output logic       done
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t     state;
   logic [3:0] shreg;
   logic [1:0] cnt;
   logic       last_bit;
   logic       out_bit;

   assign last_bit = (state == SHIFT) && (cnt == 2'd3);
   assign ready    = (state == IDLE) || last_bit;

   assign out_bit  = LSB_FIRST ? shreg[0] : shreg[3];
   assign busy     = (state == SHIFT);
   assign frame    = (state == SHIFT);
   assign sout     = (state == SHIFT) & out_bit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         shreg <= 4'd0;
         cnt   <= 2'd0;
         done  <= 1'b0;
      end else begin
         done <= last_bit;
         case (state)
            IDLE: begin
               if (load) begin
                  shreg <= d;
                  cnt   <= 2'd0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (cnt != 2'd3) begin
                  // Move the next bit toward whichever end drives sout.
                  shreg <= LSB_FIRST ? {1'b0, shreg[3:1]} : {shreg[2:0], 1'b0};
                  cnt   <= cnt + 2'd1;
               end else if (load) begin
                  shreg <= d;
                  cnt   <= 2'd0;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_piso4_tx.sv
// Bench for piso4_tx: both bit orders driven in parallel, checked against fixed
// vectors and against a bit-queue reference model under random stimulus.
module tb_piso4_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic       load;
   logic [3:0] d;
   logic       ready0, busy0, sout0, frame0, done0;
   logic       ready1, busy1, sout1, frame1, done1;

   int checks = 0;
   int errors = 0;

   // Reference model: the bits still to be sent, in transmit order.
   bit q0[$];
   bit q1[$];
   bit done_m;

   typedef struct {
      bit       ld;
      bit [3:0] d;
      bit       s0, s1, fr, dn, rdy;
   } vec_t;
   vec_t tab[$];

   piso4_tx #(.LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .reset(reset), .load(load), .d(d),
      .ready(ready0), .busy(busy0), .sout(sout0), .frame(frame0), .done(done0)
   );

   piso4_tx #(.LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .reset(reset), .load(load), .d(d),
      .ready(ready1), .busy(busy1), .sout(sout1), .frame(frame1), .done(done1)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(bit ld, bit [3:0] dv, bit s0, bit s1, bit fr, bit dn, bit rdy);
      vec_t v;
      v.ld = ld; v.d = dv; v.s0 = s0; v.s1 = s1; v.fr = fr; v.dn = dn; v.rdy = rdy;
      return v;
   endfunction

   task automatic model_reset();
      q0.delete();
      q1.delete();
      done_m = 1'b0;
   endtask

   task automatic model_edge(input bit l, input bit [3:0] dv);
      int n;
      n = q0.size();
      done_m = (n == 1);
      if (n > 0) begin
         void'(q0.pop_front());
         void'(q1.pop_front());
      end
      if (l && n <= 1) begin
         for (int i = 3; i >= 0; i--) q0.push_back(dv[i]);
         for (int i = 0; i <= 3; i++) q1.push_back(dv[i]);
      end
   endtask

   task automatic check_model();
      bit f;
      f = (q0.size() != 0);
      chk("m_sout0", sout0, f ? q0[0] : 1'b0);
      chk("m_sout1", sout1, f ? q1[0] : 1'b0);
      chk("m_frame0", frame0, f);
      chk("m_frame1", frame1, f);
      chk("m_busy0", busy0, f);
      chk("m_busy1", busy1, f);
      chk("m_ready0", ready0, q0.size() <= 1);
      chk("m_ready1", ready1, q1.size() <= 1);
      chk("m_done0", done0, done_m);
      chk("m_done1", done1, done_m);
   endtask

   // Drive inputs, take one rising edge, advance the model, then compare.
   task automatic cyc(input bit l, input bit [3:0] dv);
      load = l;
      d    = dv;
      @(posedge clk);
      if (!reset) model_reset();
      else model_edge(l, dv);
      #1;
      check_model();
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, "_sout0"}, sout0, 1'b0);
      chk({tag, "_sout1"}, sout1, 1'b0);
      chk({tag, "_busy0"}, busy0, 1'b0);
      chk({tag, "_frame0"}, frame0, 1'b0);
      chk({tag, "_ready0"}, ready0, 1'b1);
      chk({tag, "_ready1"}, ready1, 1'b1);
      chk({tag, "_done0"}, done0, 1'b0);
      chk({tag, "_done1"}, done1, 1'b0);
   endtask

   initial begin
      // MSB-first 1011 / LSB-first 1,1,0,1
      tab.push_back(mk(1, 4'b1011, 1, 1, 1, 0, 0));
      tab.push_back(mk(0, 4'b0000, 0, 1, 1, 0, 0));
      tab.push_back(mk(0, 4'b0000, 1, 0, 1, 0, 0));
      tab.push_back(mk(0, 4'b0000, 1, 1, 1, 0, 1));
      tab.push_back(mk(0, 4'b0000, 0, 0, 0, 1, 1));
      tab.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1));
      // Gapless 1100 then 0011
      tab.push_back(mk(1, 4'b1100, 1, 0, 1, 0, 0));
      tab.push_back(mk(0, 4'b1100, 1, 0, 1, 0, 0));
      tab.push_back(mk(0, 4'b1100, 0, 1, 1, 0, 0));
      tab.push_back(mk(0, 4'b1100, 0, 1, 1, 0, 1));
      tab.push_back(mk(1, 4'b0011, 0, 1, 1, 1, 0));
      tab.push_back(mk(0, 4'b0011, 0, 1, 1, 0, 0));
      tab.push_back(mk(0, 4'b0011, 1, 0, 1, 0, 0));
      tab.push_back(mk(0, 4'b0011, 1, 0, 1, 0, 1));
      tab.push_back(mk(0, 4'b0011, 0, 0, 0, 1, 1));
      tab.push_back(mk(0, 4'b0011, 0, 0, 0, 0, 1));
      // 0110 with an ignored load of 1111 at cnt==1
      tab.push_back(mk(1, 4'b0110, 0, 0, 1, 0, 0));
      tab.push_back(mk(0, 4'b0110, 1, 1, 1, 0, 0));
      tab.push_back(mk(1, 4'b1111, 1, 1, 1, 0, 0));
      tab.push_back(mk(0, 4'b1111, 0, 0, 1, 0, 1));
      tab.push_back(mk(0, 4'b1111, 0, 0, 0, 1, 1));
      tab.push_back(mk(0, 4'b1111, 0, 0, 0, 0, 1));
      // 1001 with d cleared right after acceptance
      tab.push_back(mk(1, 4'b1001, 1, 1, 1, 0, 0));
      tab.push_back(mk(0, 4'b0000, 0, 0, 1, 0, 0));
      tab.push_back(mk(0, 4'b0000, 0, 0, 1, 0, 0));
      tab.push_back(mk(0, 4'b0000, 1, 1, 1, 0, 1));
      tab.push_back(mk(0, 4'b0000, 0, 0, 0, 1, 1));
      tab.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1));

      reset = 1'b0;
      load  = 1'b0;
      d     = 4'd0;
      model_reset();
      #3;
      check_reset_outs("rst");
      @(negedge clk);
      reset = 1'b1;

      // Idle with load low for 10 cycles
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 4'($urandom));
         chk("idle_sout0", sout0, 1'b0);
         chk("idle_frame0", frame0, 1'b0);
         chk("idle_done0", done0, 1'b0);
      end

      foreach (tab[i]) begin
         cyc(tab[i].ld, tab[i].d);
         chk($sformatf("v%0d_sout0", i), sout0, tab[i].s0);
         chk($sformatf("v%0d_sout1", i), sout1, tab[i].s1);
         chk($sformatf("v%0d_frame", i), frame0, tab[i].fr);
         chk($sformatf("v%0d_done", i), done0, tab[i].dn);
         chk($sformatf("v%0d_ready", i), ready0, tab[i].rdy);
      end

      // Asynchronous reset mid-frame, after the second bit of 1111
      cyc(1'b1, 4'b1111);
      cyc(1'b0, 4'b1111);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_reset_outs("async");
      cyc(1'b1, 4'b1111);
      check_reset_outs("hold1");
      cyc(1'b1, 4'b1010);
      check_reset_outs("hold2");
      #3;
      reset = 1'b1;
      cyc(1'b0, 4'b0000);
      chk("post_rst_done", done0, 1'b0);
      chk("post_rst_frame", frame0, 1'b0);
      cyc(1'b1, 4'b0101);
      chk("r_b0", sout0, 1'b0);
      cyc(1'b0, 4'b0000);
      chk("r_b1", sout0, 1'b1);
      cyc(1'b0, 4'b0000);
      chk("r_b2", sout0, 1'b0);
      cyc(1'b0, 4'b0000);
      chk("r_b3", sout0, 1'b1);
      cyc(1'b0, 4'b0000);
      chk("r_done", done0, 1'b1);
      chk("r_frame_end", frame0, 1'b0);

      // Random traffic with occasional mid-cycle resets
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 1)), 4'($urandom));
         if ($urandom_range(0, 39) == 0) begin
            #2;
            reset = 1'b0;
            #1;
            model_reset();
            check_model();
            #1;
            reset = 1'b1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/piso4_tx.md
PISO4_TX -- requirements
Module: piso4_tx

Interface
REQ-001 The block SHALL have one parameter: LSB_FIRST, default 0, meaning 0 = transmit d[3] first and 1 = transmit d[0] first.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port load, input, 1 bit: request to capture d and start a 4-bit serial frame.
REQ-005 The block SHALL have port d, input, 4 bits: parallel word to transmit.
REQ-006 The block SHALL have port ready, output, 1 bit: high when a load on the next rising edge will be accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a frame is being shifted out.
REQ-008 The block SHALL have port sout, output, 1 bit: serial data bit of the current frame.
REQ-009 The block SHALL have port frame, output, 1 bit: qualifies sout; high exactly during the 4 data-bit cycles.
REQ-010 The block SHALL have port done, output, 1 bit: single-cycle pulse after the last bit of a frame.

Function
REQ-011 The block SHALL implement two states: IDLE and SHIFT, with a 4-bit shift register shreg and a 2-bit bit counter cnt.
REQ-012 In IDLE, a rising edge with load=1 SHALL set shreg<=d and cnt<=0, and SHALL move the state to SHIFT.
REQ-013 In IDLE, load=0 SHALL leave all state unchanged.
REQ-014 In SHIFT, busy and frame SHALL be 1, and sout SHALL be shreg[3] (LSB_FIRST=0) or shreg[0] (LSB_FIRST=1).
REQ-015 Outside SHIFT, sout and frame SHALL be 0, and busy SHALL be 0.
REQ-016 Each rising edge in SHIFT with cnt<3 SHALL shift shreg by one position toward the output end, zero-filling, and SHALL increment cnt.
REQ-017 A rising edge in SHIFT with cnt==3 and load=0 SHALL return the state to IDLE.
REQ-018 A rising edge in SHIFT with cnt==3 and load=1 SHALL set shreg<=d and cnt<=0, and SHALL keep the state in SHIFT (gapless back-to-back frames).
REQ-019 ready SHALL be combinational: 1 in IDLE, 1 in SHIFT when cnt==3, and 0 otherwise.
REQ-020 load SHALL be ignored when ready=0; d and shreg SHALL be unaffected.
REQ-021 done SHALL be a registered output set to 1 for exactly one cycle following every rising edge that completes bit 3 of a frame, including the gapless case.
REQ-022 Latency SHALL be: first data bit on sout in the cycle immediately after the accepting edge; 4 bits on 4 consecutive cycles.
REQ-023 d SHALL be sampled only on accepting edges; later changes of d SHALL NOT affect the frame in progress.

Reset
REQ-024 reset=0 SHALL immediately, without waiting for clk, force the state to IDLE, shreg=0, cnt=0 and done=0, giving ready=1, busy=0, sout=0 and frame=0.
REQ-025 reset asserted mid-frame SHALL abort the frame; no done pulse SHALL follow, and the first frame after release SHALL start only on a new accepted load.
REQ-026 Outputs SHALL stay at their reset values while reset=0 regardless of load.

Verification
REQ-027 The bench SHALL cover: LSB_FIRST=0, load=1 with d=1011 for one cycle -> sout=1,0,1,1 on the next 4 cycles with frame=1, then done=1 for one cycle and frame=0.
REQ-028 The bench SHALL cover: LSB_FIRST=1, d=0110 -> sout=0,1,1,0; then a load with d=1111 while cnt=1 -> ignored, the frame is unchanged and no extra frame follows.
REQ-029 The bench SHALL cover: d=1100, with load held on the cnt==3 edge and d=0011 -> 8 consecutive frame=1 cycles carrying sout=1,1,0,0,0,0,1,1, and two done pulses.
REQ-030 The bench SHALL cover: load d=1001, then d changes to 0000 after acceptance -> sout still 1,0,0,1.
REQ-031 The bench SHALL cover: reset=0 asserted between clock edges after the second bit of d=1111 -> sout=0, busy=0 and ready=1 immediately, with no done pulse; after release, load d=0101 -> normal frame 0,1,0,1.
REQ-032 The bench SHALL cover: load=0 held for 10 cycles after reset -> sout=0, frame=0 and done=0 throughout.
